// File: rtl/softmax_sum_ln.sv
// softmax_sum_ln: accumulates one row of exp values, then produces ln(sum) in fixed point
module softmax_sum_ln #(
  parameter int DW = 32,
  parameter int FRAC = 10,
  parameter int AW = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [DW-1:0] exp_in,
  output logic          in_ready,
  output logic          busy,
  output logic [DW-1:0] lnF,
  output logic          lnF_valid,
  output logic [DW-1:0] sum_out,
  output logic          ovf,
  output logic          sum_zero
);
  localparam int PW = $clog2(AW);
  typedef enum logic [1:0] {IDLE, ACC, LOD, MUL} state_t;
  state_t state, state_n;
  logic [AW-1:0] acc;
  logic [AW:0] acc_sum;
  logic [PW-1:0] p, lod_p;
  logic [FRAC-1:0] m, lod_m;
  logic signed [47:0] log2_v;
  logic take;
  assign take = in_ready & in_valid;
  assign acc_sum = {1'b0, acc} + (AW+1)'(exp_in);
  assign log2_v = ((48'(p) - 48'(FRAC)) << FRAC) + 48'(m);
  // leading-one detector; the shift lines up the FRAC bits below the leading one
  always_comb begin
    lod_p = '0;
    for (int i = 0; i < AW; i++) lod_p = acc[i] ? PW'(i) : lod_p;
    lod_m = FRAC'({acc, FRAC'(0)} >> lod_p);
  end
  // next-state logic: a row runs IDLE -> ACC -> LOD -> MUL -> IDLE
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = ACC;
    if (take && in_last) state_n = LOD;
    if (state == LOD) state_n = MUL;
    if (state == MUL) state_n = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // datapath and registered outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      p <= '0;
      m <= '0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      lnF <= '0;
      lnF_valid <= 1'b0;
      sum_out <= '0;
      ovf <= 1'b0;
      sum_zero <= 1'b0;
    end else begin
      in_ready <= state_n == ACC;
      busy <= state_n != IDLE;
      lnF_valid <= state == MUL;
      if (state == IDLE && start) begin
        acc <= '0;
        ovf <= 1'b0;
        sum_zero <= 1'b0;
      end
      if (take) begin
        acc <= acc_sum[AW] ? '1 : acc_sum[AW-1:0];
        if (acc_sum[AW]) ovf <= 1'b1;
      end
      if (state == LOD) begin
        p <= lod_p;
        m <= lod_m;
      end
      if (state == MUL) begin
        lnF <= (acc == '0) ? '0 : DW'((log2_v * 48'sd710) >>> FRAC);
        sum_out <= (|acc[AW-1:DW]) ? '1 : acc[DW-1:0];
        sum_zero <= acc == '0;
      end
    end
endmodule

// File: tb/tb_softmax_sum_ln.sv
// tb_softmax_sum_ln: table vectors, corner sequences and random rows against a reference model
module tb_softmax_sum_ln;
  logic clk = 0, rst = 0, start = 0, in_valid = 0, in_last = 0;
  logic [31:0] exp_in = 0;
  logic in_ready, busy, lnF_valid, ovf, sum_zero;
  logic [31:0] lnF, sum_out;
  int checks = 0, failures = 0;
  logic [31:0] q[$];
  typedef struct {
    int n;
    logic [31:0] v, e_ln, e_sum;
    bit e_ovf, e_zero;
  } vec_t;
  vec_t tbl[6];

  softmax_sum_ln dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .exp_in(exp_in), .in_ready(in_ready), .busy(busy), .lnF(lnF),
    .lnF_valid(lnF_valid), .sum_out(sum_out), .ovf(ovf), .sum_zero(sum_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // expected results straight from the arithmetic definition of the row sum and its log
  task automatic model(output logic [31:0] e_ln, output logic [31:0] e_sum,
                       output bit e_ovf, output bit e_zero);
    longint unsigned s, cap;
    longint signed l2, mm;
    int p;
    s = 0;
    cap = (64'd1 << 40) - 1;
    e_ovf = 0;
    foreach (q[i]) begin
      s = s + q[i];
      if (s > cap) begin
        s = cap;
        e_ovf = 1;
      end
    end
    e_sum = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    e_zero = (s == 0);
    if (s == 0) e_ln = 0;
    else begin
      p = 0;
      while ((s >> (p + 1)) != 0) p++;
      mm = longint'(((s << 10) >> p) % 1024);
      l2 = (longint'(p) - 10) * 1024 + mm;
      e_ln = 32'((l2 * 710) >>> 10);
    end
  endtask

  task automatic run_row(input string nm, input logic [31:0] e_ln, input logic [31:0] e_sum,
                         input bit e_ovf, input bit e_zero, input bit gaps);
    start = 1;
    step();
    start = 0;
    chk({nm, " in_ready"}, in_ready, 1);
    chk({nm, " busy"}, busy, 1);
    foreach (q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_valid = 0;
        in_last = 1'($urandom);
        exp_in = $urandom;
        step();
      end
      in_valid = 1;
      exp_in = q[i];
      in_last = (i == q.size() - 1);
      step();
    end
    in_valid = 0;
    in_last = 0;
    chk({nm, " valid k"}, lnF_valid, 0);
    step();
    chk({nm, " valid k+1"}, lnF_valid, 0);
    step();
    chk({nm, " valid k+2"}, lnF_valid, 1);
    chk({nm, " lnF"}, lnF, e_ln);
    chk({nm, " sum_out"}, sum_out, e_sum);
    chk({nm, " ovf"}, ovf, e_ovf);
    chk({nm, " sum_zero"}, sum_zero, e_zero);
    chk({nm, " busy idle"}, busy, 0);
    step();
    chk({nm, " valid k+3"}, lnF_valid, 0);
    chk({nm, " lnF hold"}, lnF, e_ln);
  endtask

  initial begin
    logic [31:0] e_ln, e_sum;
    bit e_ovf, e_zero;
    tbl[0] = '{4, 32'd1024, 32'd1420, 32'd4096, 0, 0};
    tbl[1] = '{1, 32'd1024, 32'd0, 32'd1024, 0, 0};
    tbl[2] = '{1, 32'd3072, 32'd1065, 32'd3072, 0, 0};
    tbl[3] = '{1, 32'd512, 32'hFFFF_FD3A, 32'd512, 0, 0};
    tbl[4] = '{1, 32'd0, 32'd0, 32'd0, 0, 1};
    tbl[5] = '{300, 32'hFFFF_FFFF, 32'd21299, 32'hFFFF_FFFF, 1, 0};

    step();
    step();
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset lnF", lnF, 0);
    chk("reset lnF_valid", lnF_valid, 0);
    chk("reset sum_out", sum_out, 0);
    rst = 1;
    step();

    for (int t = 0; t < 6; t++) begin
      q.delete();
      repeat (tbl[t].n) q.push_back(tbl[t].v);
      run_row($sformatf("vec%0d", t), tbl[t].e_ln, tbl[t].e_sum, tbl[t].e_ovf, tbl[t].e_zero, 0);
    end

    start = 1;
    step();
    start = 0;
    in_valid = 1;
    exp_in = 1024;
    step();
    step();
    in_valid = 0;
    #2 rst = 0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst in_ready", in_ready, 0);
    chk("midrst lnF", lnF, 0);
    chk("midrst sum_out", sum_out, 0);
    chk("midrst ovf", ovf, 0);
    chk("midrst sum_zero", sum_zero, 0);
    chk("midrst lnF_valid", lnF_valid, 0);
    step();
    chk("inrst lnF_valid", lnF_valid, 0);
    rst = 1;
    q.delete();
    q.push_back(2048);
    run_row("post_rst", 32'd710, 32'd2048, 0, 0, 0);

    start = 1;
    in_valid = 1;
    exp_in = 5000;
    in_last = 1;
    step();
    start = 0;
    exp_in = 1024;
    in_last = 0;
    step();
    start = 1;
    step();
    start = 0;
    in_last = 1;
    step();
    in_valid = 0;
    in_last = 0;
    chk("ign busy", busy, 1);
    step();
    step();
    chk("ign valid", lnF_valid, 1);
    chk("ign lnF", lnF, 1065);
    chk("ign sum_out", sum_out, 3072);
    in_valid = 1;
    in_last = 1;
    exp_in = 7;
    repeat (3) step();
    in_valid = 0;
    in_last = 0;
    chk("idle beat busy", busy, 0);
    chk("idle beat in_ready", in_ready, 0);
    chk("idle beat valid", lnF_valid, 0);
    chk("idle beat sum_out", sum_out, 3072);

    for (int r = 0; r < 25; r++) begin
      q.delete();
      repeat ($urandom_range(1, 8))
        q.push_back(($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31)));
      model(e_ln, e_sum, e_ovf, e_zero);
      run_row($sformatf("rnd%0d", r), e_ln, e_sum, e_ovf, e_zero, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/softmax_sum_ln.md
SOFTMAX_SUM_LN -- requirements
Module: softmax_sum_ln

Interface
REQ-001 Parameter DW, default `OUTPUT_BUF_DATASIZE (32): data width of exp_in, lnF, sum_out.
REQ-002 Parameter FRAC, default `FIXPOINT_FRAC (10): fraction bits of all fixed-point values.
REQ-003 Parameter AW, default 40: accumulator width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a new row sum; honoured only in IDLE.
REQ-007 in_valid  input  1  exp_in carries a valid beat.
REQ-008 in_last  input  1  qualifies the final beat of a row; sampled only with in_valid.
REQ-009 exp_in  input  DW  unsigned Q(DW-FRAC).FRAC value from the exp stage (stage-2 pass).
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 busy  output  1  state is not IDLE.
REQ-012 lnF  output  DW  signed Q(DW-FRAC).FRAC natural log of the row sum; consumed by exp in stage 4.
REQ-013 lnF_valid  output  1  one-cycle pulse; lnF is new.
REQ-014 sum_out  output  DW  row sum, saturated to DW bits.
REQ-015 ovf  output  1  sticky per row: accumulator saturated.
REQ-016 sum_zero  output  1  per row: final sum equal to 0.

Function
REQ-017 FSM states: IDLE, ACC, LOD, MUL; encoding free; all outputs registered.
REQ-018 IDLE: start=1 -> clear acc, ovf, sum_zero; go to ACC; otherwise stay.
REQ-019 in_ready SHALL be 1 exactly when state is ACC; a beat is accepted when in_valid & in_ready.
REQ-020 ACC: accepted beat -> acc = acc + zero-extended exp_in, saturating at 2^AW-1 and setting ovf on saturation.
REQ-021 ACC: accepted beat with in_last=1 -> go to LOD, including that beat in the sum.
REQ-022 LOD: register p = index of the leading one of acc (0..AW-1), m = the FRAC bits directly below it (zero-padded on the right when p<FRAC); go to MUL.
REQ-023 MUL: log2 = ((p-FRAC) << FRAC) + m, signed; lnF = (log2 * 710) >>> FRAC (710 = ln2 in Q.10, arithmetic shift, floor); pulse lnF_valid; update sum_out; go to IDLE.
REQ-024 acc = 0 at LOD -> lnF = 0, sum_zero = 1, still pulse lnF_valid.
REQ-025 sum_out = acc when acc < 2^DW, else 2^DW-1.
REQ-026 Latency: last beat accepted at edge k -> lnF/lnF_valid updated at edge k+2; lnF_valid high for exactly one cycle.
REQ-027 lnF, sum_out, ovf, sum_zero hold until the next MUL state.
REQ-028 start outside IDLE SHALL be ignored; start and in_valid in the same IDLE cycle -> beat not accepted.
REQ-029 in_valid with in_ready=0 SHALL have no effect; upstream holds the beat.
REQ-030 A row with no beats does not complete; ACC waits indefinitely for in_last.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, acc=0, lnF=0, sum_out=0, lnF_valid=0, ovf=0, sum_zero=0, in_ready=0, busy=0, including mid-row; the aborted row produces no lnF_valid.
REQ-032 After rst deasserts, the first rising edge SHALL be able to honour start.

Verification
REQ-033 start; 4 beats of 1024 (1.0), last on 4th -> sum_out=4096, lnF=1420, lnF_valid 2 cycles after last beat.
REQ-034 start; single beat 1024 with in_last -> lnF=0, sum_zero=0.
REQ-035 start; beat 3072 (3.0) last -> p=11, m=512, lnF=1065; beat 512 (0.5) last in next row -> lnF=0xFFFFFD3A (-710).
REQ-036 start; beat 0 last -> lnF=0, sum_zero=1; beats 0xFFFFFFFF x 300 -> ovf=1, sum_out=0xFFFFFFFF, lnF=(29*1024+1023)*710>>10.
REQ-037 rst pulsed low mid-row after 2 beats -> all outputs 0 immediately, no lnF_valid; new row after reset computes from empty accumulator.
REQ-038 start asserted during ACC, and in_valid with start in IDLE -> both ignored; sum unchanged.
